fetch_pc_ctrl: RTL
==================

# fetch_pc_ctrl

Fetch sequencer in front of the `frontend` (fetch/decode) pipeline. It owns the architectural fetch PC, advances it on downstream acceptance, and performs mispredict redirects: it loads the target, pulses a flush, holds fetch for a fixed recovery window, and tags the stream with an epoch bit. Returning fetch responses from the stale path are filtered by that epoch bit. Sits between the branch-resolution/commit logic (redirect source) and the fetch stage PC input.

## Interface
- `RESET_PC`, default 32'h0000_0000: fetch PC after reset.
- `FLUSH_CYCLES`, default 1: cycles `pc_valid` is held low after a redirect; legal range 1..7.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  reset, synchronous, active-low.
- `redirect_valid`  in  1  mispredict/redirect request; single-cycle or level.
- `redirect_pc`  in  32  redirect target.
- `halt_req`  in  1  level; stop issuing PCs while high.
- `fetch_ready`  in  1  fetch stage accepts `pc_out` this cycle.
- `pc_out`  out  32  current fetch PC (registered).
- `pc_valid`  out  1  `pc_out` is a request (registered).
- `flush_out`  out  1  one-cycle pulse; frontend must drop all in-flight instructions.
- `epoch_out`  out  1  current stream epoch (registered).
- `resp_valid`  in  1  fetch/decode response present.
- `resp_epoch`  in  1  epoch the response was fetched under.
- `resp_keep`  out  1  combinational: `resp_valid && resp_epoch==epoch_out && !flush_out`.
- `fetch_cnt`  out  32  accepted-fetch count (see Configuration).
- `redirect_cnt`  out  32  accepted-redirect count (see Configuration).

## Operation
- States: BOOT, RUN, FLUSH, HALT. Priority: reset > redirect > halt > advance.
- Reset (`reset==0` at edge): state BOOT, `pc_out=RESET_PC`, `pc_valid=0`, `flush_out=0`, `epoch_out=0`, flush counter 0, counters 0. Reset mid-flush or mid-halt aborts it.
- BOOT: next edge -> RUN (or FLUSH if `redirect_valid`, or HALT if `halt_req`).
- RUN: `pc_valid=1`. Handshake = `pc_valid && fetch_ready`; on handshake `pc_out += 4` (mod 2^32, so 0xFFFF_FFFC -> 0x0000_0000). No handshake -> hold PC.
- Redirect accepted in any non-reset state: `pc_out <= {redirect_pc[31:2],2'b00}`, `epoch_out` toggles, `flush_out` is 1 next cycle, counter loads `FLUSH_CYCLES`, state -> FLUSH. A handshake in the same cycle is discarded (no +4).
- FLUSH: `pc_valid=0`; counter decrements per cycle; at 1 -> next state RUN (HALT if `halt_req`). A redirect during FLUSH restarts it: new target, epoch toggles again, new `flush_out` pulse, counter reloads.
- `halt_req` in RUN (no redirect): -> HALT, `pc_valid=0`, PC held. HALT -> RUN when `halt_req` drops. Redirect in HALT -> FLUSH.
- `redirect_valid` held several cycles: treated as a new redirect each cycle (epoch toggles each cycle).

## Timing
- Redirect sampled at edge N: at N+1 `pc_out=target`, `flush_out=1`, `epoch_out` flipped, `pc_valid=0`. `pc_valid` returns at edge N+FLUSH_CYCLES with `pc_out=target`; default gives exactly one bubble.
- Advance latency: handshake at edge N -> `pc_out+4` visible after N.
- `resp_keep` has zero latency and is forced 0 during the `flush_out` cycle.
- Reset release: first `pc_valid=1` (PC=`RESET_PC`) one cycle after BOOT.

## Configuration
- `FETCH_PERF_CNT_EN` defined: `fetch_cnt` increments on each handshake and `redirect_cnt` on each accepted redirect. Both are saturating at 32'hFFFF_FFFF and cleared by reset.
- Not defined: both ports remain and are tied to 0; no counter flops.

## Test plan
- Reset with `RESET_PC=0`, `fetch_ready=1`: BOOT one cycle, then `pc_out` 0,4,8,C on consecutive cycles, `pc_valid=1`, `epoch_out=0`.
- Redirect to 0x42 while `pc_out=0xC`: next cycle `pc_out=0x40`, `flush_out=1`, `epoch_out=1`, `pc_valid=0` one cycle. Then 0x40,0x44,0x48. A response with `resp_epoch=0` gives `resp_keep=0`; one with `resp_epoch=1` gives `resp_keep=1`.
- `fetch_ready=0` for 3 cycles at PC 0x8: `pc_out` held at 0x8, no count increment, advances to 0xC after ready returns.
- `FLUSH_CYCLES=3`; redirect to 0x100, second redirect to 0x200 in the 2nd flush cycle: epoch toggles twice (back to 0), two `flush_out` pulses, `pc_valid` resumes 3 cycles after the second redirect with 0x200.
- Redirect to 0xFFFF_FFFC, then run: 0xFFFF_FFFC -> 0x0. `halt_req` high 2 cycles: `pc_valid=0` and PC held. Reset asserted during halt: `pc_out=RESET_PC`, state BOOT.
- With `FETCH_PERF_CNT_EN`: 5 handshakes plus 2 redirects give `fetch_cnt=5`, `redirect_cnt=2`. Without the macro both read 0.

Source files
------------

// File: rtl/fetch_pc_ctrl.sv
// Fetch sequencer: owns the fetch PC, advances it on downstream acceptance, and runs mispredict redirect/flush/epoch.
// Optional FETCH_PERF_CNT_EN adds saturating fetch/redirect counters; otherwise the counter ports read 0.
module fetch_pc_ctrl #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int unsigned FLUSH_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt_req,
  input  logic        fetch_ready,
  output logic [31:0] pc_out,
  output logic        pc_valid,
  output logic        flush_out,
  output logic        epoch_out,
  input  logic        resp_valid,
  input  logic        resp_epoch,
  output logic        resp_keep,
  output logic [31:0] fetch_cnt,
  output logic [31:0] redirect_cnt
);

  typedef enum logic [1:0] {BOOT, RUN, FLUSH, HALT} state_t;

  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES);

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        pc_valid_q, pc_valid_d;
  logic        flush_q, flush_d;
  logic        epoch_q, epoch_d;
  logic [2:0]  fcnt_q, fcnt_d;
  logic        advance;

  // Target is word aligned; the low bits of the redirect address are dropped.
  logic unused_pc_bits;
  assign unused_pc_bits = &{1'b0, redirect_pc[1:0]};

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    flush_d = 1'b0;
    epoch_d = epoch_q;
    fcnt_d  = fcnt_q;
    advance = 1'b0;
    if (redirect_valid) begin
      state_d = FLUSH;
      pc_d    = {redirect_pc[31:2], 2'b00};
      flush_d = 1'b1;
      epoch_d = ~epoch_q;
      fcnt_d  = FLUSH_LOAD;
    end else begin
      case (state_q)
        BOOT:  state_d = halt_req ? HALT : RUN;
        RUN: begin
          if (halt_req) begin
            state_d = HALT;
          end else if (pc_valid_q && fetch_ready) begin
            advance = 1'b1;
            pc_d    = pc_q + 32'd4;
          end
        end
        FLUSH: begin
          fcnt_d = fcnt_q - 3'd1;
          if (fcnt_q <= 3'd1) begin
            fcnt_d  = 3'd0;
            state_d = halt_req ? HALT : RUN;
          end
        end
        HALT:    if (!halt_req) state_d = RUN;
        default: state_d = BOOT;
      endcase
    end
    pc_valid_d = (state_d == RUN);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= BOOT;
      pc_q       <= RESET_PC;
      pc_valid_q <= 1'b0;
      flush_q    <= 1'b0;
      epoch_q    <= 1'b0;
      fcnt_q     <= 3'd0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pc_valid_q <= pc_valid_d;
      flush_q    <= flush_d;
      epoch_q    <= epoch_d;
      fcnt_q     <= fcnt_d;
    end
  end

  assign pc_out    = pc_q;
  assign pc_valid  = pc_valid_q;
  assign flush_out = flush_q;
  assign epoch_out = epoch_q;
  // Stale-path responses and anything in flight during the flush pulse are dropped.
  assign resp_keep = resp_valid && (resp_epoch == epoch_q) && !flush_q;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] redirect_cnt_q, redirect_cnt_d;

  always_comb begin
    fetch_cnt_d    = fetch_cnt_q;
    redirect_cnt_d = redirect_cnt_q;
    if (advance && (fetch_cnt_q != 32'hFFFF_FFFF)) fetch_cnt_d = fetch_cnt_q + 32'd1;
    if (redirect_valid && (redirect_cnt_q != 32'hFFFF_FFFF)) redirect_cnt_d = redirect_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      fetch_cnt_q    <= 32'd0;
      redirect_cnt_q <= 32'd0;
    end else begin
      fetch_cnt_q    <= fetch_cnt_d;
      redirect_cnt_q <= redirect_cnt_d;
    end
  end

  assign fetch_cnt    = fetch_cnt_q;
  assign redirect_cnt = redirect_cnt_q;
`else
  logic unused_advance;
  assign unused_advance = advance;
  assign fetch_cnt      = 32'd0;
  assign redirect_cnt   = 32'd0;
`endif

endmodule
